gpio_axi_wr_slave: RTL and testbench

- Single-beat AXI4 write slave holding the three GPIO control registers: DATA, DIRM and OEN.
- Consumes the AW and W channels driven by the GPIO init controller, which writes 0xE000A204, 0xE000A208, then 0xE000A040.
- Updates the addressed register, drives the GPIO pins and returns the B response, which closes the write loop the controller opens.

---
 rtl/gpio_axi_pkg.sv | 51 +++++
 rtl/gpio_axi_wr_slave_if.sv | 31 +++
 rtl/gpio_axi_regfile.sv | 52 +++++
 rtl/gpio_axi_wr_slave.sv | 151 +++++++++++++++
 tb/tb_gpio_axi_wr_slave.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_axi_pkg.sv
// Shared types, response codes and register offsets for the GPIO AXI write slave.
// Helpers: window decode and byte-strobe merge.
package gpio_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_DATA = 2'd0,
    SEL_DIRM = 2'd1,
    SEL_OEN  = 2'd2,
    SEL_NONE = 2'd3
  } reg_sel_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [11:0] OFF_DATA = 12'h040;
  localparam logic [11:0] OFF_DIRM = 12'h204;
  localparam logic [11:0] OFF_OEN  = 12'h208;

  // base_page is the 4 KB page number of the register window (address bits 31:12).
  function automatic reg_sel_e decode_sel(input logic [31:0] addr, input logic [19:0] base_page);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (addr[31:12] == base_page) begin
      case (addr[11:0])
        OFF_DATA: sel = SEL_DATA;
        OFF_DIRM: sel = SEL_DIRM;
        OFF_OEN:  sel = SEL_OEN;
        default:  sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val, input logic [31:0] wdata,
                                             input logic [3:0] wstrb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gpio_axi_wr_slave_if.sv
// AXI4 write-channel bundle (AW, W, B) for the GPIO register slave.
// Handshake: a transfer occurs on a rising edge where valid and ready are both high; valid never waits on ready.
interface gpio_axi_wr_slave_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic            awvalid;
  logic            awready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output awid, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/gpio_axi_regfile.sv
// DATA / DIRM / OEN registers with byte-strobe merge and parameterised reset values.
module gpio_axi_regfile
  import gpio_axi_pkg::*;
#(
  parameter logic [31:0] RST_DATA = 32'h0000_0000,
  parameter logic [31:0] RST_DIRM = 32'h0000_0000,
  parameter logic [31:0] RST_OEN  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  reg_sel_e    sel,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] data_o,
  output logic [31:0] dirm_o,
  output logic [31:0] oen_o
);
  logic [31:0] data_q, data_d;
  logic [31:0] dirm_q, dirm_d;
  logic [31:0] oen_q,  oen_d;

  always_comb begin
    data_d = data_q;
    dirm_d = dirm_q;
    oen_d  = oen_q;
    if (we) begin
      case (sel)
        SEL_DATA: data_d = strb_merge(data_q, wdata, wstrb);
        SEL_DIRM: dirm_d = strb_merge(dirm_q, wdata, wstrb);
        SEL_OEN:  oen_d  = strb_merge(oen_q,  wdata, wstrb);
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RST_DATA;
      dirm_q <= RST_DIRM;
      oen_q  <= RST_OEN;
    end else begin
      data_q <= data_d;
      dirm_q <= dirm_d;
      oen_q  <= oen_d;
    end
  end

  assign data_o = data_q;
  assign dirm_o = dirm_q;
  assign oen_o  = oen_q;
endmodule

// File: rtl/gpio_axi_wr_slave.sv
// Single-beat AXI4 write slave for the GPIO DATA/DIRM/OEN registers; all outputs registered.
// Optional macro GPIO_WR_STRICT_SIZE_EN: reject any awsize other than 4 bytes with SLVERR.
module gpio_axi_wr_slave
  import gpio_axi_pkg::*;
#(
  parameter int          ID_W      = 4,
  parameter logic [31:0] BASE_ADDR = 32'hE000A000,
  parameter logic [31:0] RST_DATA  = 32'h0000_0000,
  parameter logic [31:0] RST_DIRM  = 32'h0000_0000,
  parameter logic [31:0] RST_OEN   = 32'h0000_0000
) (
  input  logic            s00_axi_aclk,
  input  logic            s00_axi_aresetn,
  input  logic [ID_W-1:0] s00_axi_awid,
  input  logic [31:0]     s00_axi_awaddr,
  input  logic [7:0]      s00_axi_awlen,
  input  logic [2:0]      s00_axi_awsize,
  input  logic            s00_axi_awvalid,
  output logic            s00_axi_awready,
  input  logic [31:0]     s00_axi_wdata,
  input  logic [3:0]      s00_axi_wstrb,
  input  logic            s00_axi_wlast,
  input  logic            s00_axi_wvalid,
  output logic            s00_axi_wready,
  output logic [ID_W-1:0] s00_axi_bid,
  output logic [1:0]      s00_axi_bresp,
  output logic            s00_axi_bvalid,
  input  logic            s00_axi_bready,
  output logic [31:0]     gpio_data,
  output logic [31:0]     gpio_dirm,
  output logic [31:0]     gpio_oen
);
  state_e          state_q, state_d;
  logic            awready_q, awready_d;
  logic            wready_q, wready_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [ID_W-1:0] bid_q, bid_d;
  reg_sel_e        sel_q, sel_d;
  logic [7:0]      awlen_q, awlen_d;
  logic [7:0]      beat_q, beat_d;

  logic     aw_hs, w_hs, b_hs, size_bad, reg_we;
  logic [1:0] aw_code;
  reg_sel_e aw_sel;

`ifdef GPIO_WR_STRICT_SIZE_EN
  assign size_bad = (s00_axi_awsize != 3'b010);
`else
  logic unused_awsize;
  assign unused_awsize = ^s00_axi_awsize;
  assign size_bad      = 1'b0;
`endif

  assign aw_hs  = (state_q == ST_IDLE) && s00_axi_awvalid && awready_q;
  assign w_hs   = (state_q == ST_DATA) && s00_axi_wvalid && wready_q;
  assign b_hs   = (state_q == ST_RESP) && s00_axi_bready && bvalid_q;
  assign aw_sel = decode_sel(s00_axi_awaddr, BASE_ADDR[31:12]);

  // DECERR outranks SLVERR when both apply.
  always_comb begin
    if (aw_sel == SEL_NONE)                    aw_code = RESP_DECERR;
    else if (s00_axi_awlen != 8'd0 || size_bad) aw_code = RESP_SLVERR;
    else                                       aw_code = RESP_OKAY;
  end

  // Only a single-beat OKAY transfer whose first beat carries wlast commits.
  assign reg_we = w_hs && (beat_q == 8'd0) && s00_axi_wlast && (bresp_q == RESP_OKAY);

  always_comb begin
    state_d = state_q;
    bresp_d = bresp_q;
    bid_d   = bid_q;
    sel_d   = sel_q;
    awlen_d = awlen_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          state_d = ST_DATA;
          bid_d   = s00_axi_awid;
          sel_d   = aw_sel;
          awlen_d = s00_axi_awlen;
          bresp_d = aw_code;
          beat_d  = 8'd0;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          beat_d = (beat_q == 8'hFF) ? 8'hFF : beat_q + 8'd1;
          if (beat_q == 8'd0 && !s00_axi_wlast && awlen_q == 8'd0 && bresp_q == RESP_OKAY)
            bresp_d = RESP_SLVERR;
          if (s00_axi_wlast) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (b_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    awready_d = (state_d == ST_IDLE);
    wready_d  = (state_d == ST_DATA);
    bvalid_d  = (state_d == ST_RESP);
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q   <= ST_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      sel_q     <= SEL_NONE;
      awlen_q   <= 8'd0;
      beat_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      sel_q     <= sel_d;
      awlen_q   <= awlen_d;
      beat_q    <= beat_d;
    end
  end

  gpio_axi_regfile #(
    .RST_DATA (RST_DATA),
    .RST_DIRM (RST_DIRM),
    .RST_OEN  (RST_OEN)
  ) u_regfile (
    .clk    (s00_axi_aclk),
    .rst_n  (s00_axi_aresetn),
    .we     (reg_we),
    .sel    (sel_q),
    .wdata  (s00_axi_wdata),
    .wstrb  (s00_axi_wstrb),
    .data_o (gpio_data),
    .dirm_o (gpio_dirm),
    .oen_o  (gpio_oen)
  );

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_bid     = bid_q;
endmodule

// File: tb/tb_gpio_axi_wr_slave.sv
// Bench for gpio_axi_wr_slave: AXI write driver, register model, B-response scoreboard.
module tb_gpio_axi_wr_slave;
`ifdef GPIO_WR_STRICT_SIZE_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] gpio_data, gpio_dirm, gpio_oen;

  gpio_axi_wr_slave_if #(.ID_W(4)) axi ();

  gpio_axi_wr_slave dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi_awid    (axi.awid),
    .s00_axi_awaddr  (axi.awaddr),
    .s00_axi_awlen   (axi.awlen),
    .s00_axi_awsize  (axi.awsize),
    .s00_axi_awvalid (axi.awvalid),
    .s00_axi_awready (axi.awready),
    .s00_axi_wdata   (axi.wdata),
    .s00_axi_wstrb   (axi.wstrb),
    .s00_axi_wlast   (axi.wlast),
    .s00_axi_wvalid  (axi.wvalid),
    .s00_axi_wready  (axi.wready),
    .s00_axi_bid     (axi.bid),
    .s00_axi_bresp   (axi.bresp),
    .s00_axi_bvalid  (axi.bvalid),
    .s00_axi_bready  (axi.bready),
    .gpio_data       (gpio_data),
    .gpio_dirm       (gpio_dirm),
    .gpio_oen        (gpio_oen)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  int w_hs_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (axi.wvalid && axi.wready) w_hs_cnt <= w_hs_cnt + 1;
  end

  // scoreboard: {bid, bresp} per accepted AW
  logic [5:0]  exp_q[$];
  logic [31:0] exp_data = 32'h0, exp_dirm = 32'h0, exp_oen = 32'h0;
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, ".data"}, gpio_data, exp_data);
    chk({tag, ".dirm"}, gpio_dirm, exp_dirm);
    chk({tag, ".oen"},  gpio_oen,  exp_oen);
  endtask

  // drivers
  task automatic wait_high(input string tag, input int which);
    int guard;
    logic s;
    guard = 0;
    s = (which == 0) ? axi.awready : (which == 1) ? axi.wready : axi.bvalid;
    while (s !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
      s = (which == 0) ? axi.awready : (which == 1) ? axi.wready : axi.bvalid;
    end
    if (guard >= 50) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [31:0] data, input logic [3:0] strb,
                           input int beats, input int b_delay);
    logic [1:0] resp;
    logic [5:0] exp_b;
    bit hit;
    int t_aw, w0;
    hit = (addr[31:12] == 20'hE000A) &&
          (addr[11:0] == 12'h040 || addr[11:0] == 12'h204 || addr[11:0] == 12'h208);
    if (!hit) resp = 2'b11;
    else if (len != 8'd0 || (STRICT && size != 3'b010) || beats != 1) resp = 2'b10;
    else resp = 2'b00;
    exp_q.push_back({id, resp});

    @(negedge clk);
    axi.awaddr = addr; axi.awid = id; axi.awlen = len; axi.awsize = size; axi.awvalid = 1'b1;
    wait_high("awready", 0);
    w0 = w_hs_cnt;
    @(negedge clk);
    t_aw = cyc;
    axi.awvalid = 1'b0;
    chk("awready_low_in_data", {31'd0, axi.awready}, 32'd0);
    chk("wready_high_in_data", {31'd0, axi.wready}, 32'd1);
    for (int b = 0; b < beats; b++) begin
      axi.wdata = data; axi.wstrb = strb; axi.wlast = (b == beats - 1); axi.wvalid = 1'b1;
      wait_high("wready", 1);
      @(negedge clk);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    chk("w_handshakes", w_hs_cnt - w0, beats);
    chk("bvalid_after_w", {31'd0, axi.bvalid}, 32'd1);
    chk("wready_after_w", {31'd0, axi.wready}, 32'd0);

    if (resp == 2'b00) begin
      case (addr[11:0])
        12'h040: exp_data = merge(exp_data, data, strb);
        12'h204: exp_dirm = merge(exp_dirm, data, strb);
        default: exp_oen  = merge(exp_oen,  data, strb);
      endcase
    end
    check_regs("regs_after_w");

    // stall B while offering a competing AW that must not be taken
    for (int d = 0; d < b_delay; d++) begin
      axi.awaddr = 32'hE000A040; axi.awvalid = 1'b1;
      @(negedge clk);
      chk("bvalid_held", {31'd0, axi.bvalid}, 32'd1);
      chk("awready_held_low", {31'd0, axi.awready}, 32'd0);
      chk("bresp_stable", {30'd0, axi.bresp}, {30'd0, resp});
    end
    axi.awvalid = 1'b0;

    axi.bready = 1'b1;
    wait_high("bvalid", 2);
    if (exp_q.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
    else begin
      exp_b = exp_q.pop_front();
      chk("bid", {28'd0, axi.bid}, {28'd0, exp_b[5:2]});
      chk("bresp", {30'd0, axi.bresp}, {30'd0, exp_b[1:0]});
    end
    @(negedge clk);
    axi.bready = 1'b0;
    chk("awready_after_b", {31'd0, axi.awready}, 32'd1);
    if (beats == 1 && b_delay == 0) chk("aw_to_b_cycles", cyc - t_aw, 2);
  endtask

  task automatic reset_outputs_check(input string tag);
    chk({tag, ".awready"}, {31'd0, axi.awready}, 32'd0);
    chk({tag, ".wready"},  {31'd0, axi.wready},  32'd0);
    chk({tag, ".bvalid"},  {31'd0, axi.bvalid},  32'd0);
    chk({tag, ".bresp"},   {30'd0, axi.bresp},   32'd0);
    chk({tag, ".bid"},     {28'd0, axi.bid},     32'd0);
    check_regs(tag);
  endtask

  initial begin
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = 3'b010; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;

    repeat (3) @(negedge clk);
    reset_outputs_check("reset");
    rst_n = 1'b1;
    #1 chk("awready_before_first_edge", {31'd0, axi.awready}, 32'd0);
    @(negedge clk);
    chk("awready_after_first_edge", {31'd0, axi.awready}, 32'd1);

    // init-controller sequence
    axi_write(32'hE000A204, 4'd0, 8'd0, 3'b010, 32'h0000FE01, 4'hF, 1, 0);
    axi_write(32'hE000A208, 4'd1, 8'd0, 3'b010, 32'h0000FE01, 4'hF, 1, 0);
    axi_write(32'hE000A040, 4'd2, 8'd0, 3'b010, 32'h00000001, 4'hF, 1, 0);

    // decode errors, burst errors, precedence
    axi_write(32'hE000A300, 4'd3, 8'd0, 3'b010, 32'hDEADBEEF, 4'hF, 1, 0);
    axi_write(32'hE000B204, 4'd4, 8'd0, 3'b010, 32'hDEADBEEF, 4'hF, 1, 0);
    axi_write(32'hE000A208, 4'd5, 8'd3, 3'b010, 32'h12345678, 4'hF, 4, 0);
    axi_write(32'hE000A204, 4'd6, 8'd0, 3'b010, 32'h12345678, 4'hF, 2, 0);
    axi_write(32'hE000A300, 4'd7, 8'd1, 3'b010, 32'h12345678, 4'hF, 2, 0);

    // strobe merge on a cleared DATA, with B back-pressure
    axi_write(32'hE000A040, 4'd8, 8'd0, 3'b010, 32'h00000000, 4'hF, 1, 0);
    axi_write(32'hE000A040, 4'd9, 8'd0, 3'b010, 32'hAABBCCDD, 4'b0010, 1, 5);
    chk("strb_merge_data", gpio_data, 32'h0000CC00);
    axi_write(32'hE000A040, 4'd10, 8'd0, 3'b010, 32'hFFFFFFFF, 4'b0000, 1, 0);

    // awsize only matters in the strict build
    axi_write(32'hE000A208, 4'd11, 8'd0, 3'b100, 32'h0000A5A5, 4'hF, 1, 0);

    // reset while in the DATA phase
    @(negedge clk);
    axi.awaddr = 32'hE000A040; axi.awid = 4'd12; axi.awlen = 8'd0; axi.awsize = 3'b010;
    axi.awvalid = 1'b1;
    wait_high("awready_rst", 0);
    @(negedge clk);
    axi.awvalid = 1'b0;
    chk("in_data_before_reset", {31'd0, axi.wready}, 32'd1);
    #2 rst_n = 1'b0;
    exp_data = 32'h0; exp_dirm = 32'h0; exp_oen = 32'h0;
    #1 reset_outputs_check("async_reset");
    repeat (2) @(negedge clk);
    chk("no_b_in_reset", {31'd0, axi.bvalid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("awready_after_rst", {31'd0, axi.awready}, 32'd1);
    axi_write(32'hE000A204, 4'd13, 8'd0, 3'b010, 32'h000000FF, 4'hF, 1, 0);

    // random single-beat writes across the three registers
    for (int n = 0; n < 12; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 2))
        0: a = 32'hE000A040;
        1: a = 32'hE000A204;
        default: a = 32'hE000A208;
      endcase
      axi_write(a, 4'($urandom_range(0, 15)), 8'd0, 3'b010, $urandom, 4'($urandom_range(0, 15)),
                1, $urandom_range(0, 2));
    end

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
